// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives a shared multi-cycle adder through two passes
// (a op b, then S -/+ m) and selects the reduced result in constant time.
module mod_addsub_ctrl #(
    parameter int unsigned OPW      = 512,
    parameter int unsigned MAX_WAIT = 31
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_sub_i,
    input  logic [OPW-1:0]   in_a_i,
    input  logic [OPW-1:0]   in_b_i,
    input  logic [OPW-1:0]   in_m_i,
    output logic [OPW-1:0]   result_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             error_o,
    output logic             adder_start_o,
    output logic             adder_subtract_o,
    output logic [OPW+1:0]   adder_in_a_o,
    output logic [OPW+1:0]   adder_in_b_o,
    input  logic [OPW+2:0]   adder_result_i,
    input  logic             adder_done_i
);

    localparam int unsigned AW = OPW + 2;
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue1,
        StWait1,
        StIssue2,
        StWait2,
        StFin,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic            op_sub_q, op_sub_d;
    logic [OPW-1:0]  m_q, m_d;
    logic [OPW-1:0]  s_q, s_d;
    logic            c1_q, c1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]  result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic            add_start_q, add_start_d;
    logic            add_sub_q, add_sub_d;
    logic [AW-1:0]   add_a_q, add_a_d;
    logic [AW-1:0]   add_b_q, add_b_d;

    logic            timeout;
    logic            c2;
    logic [OPW-1:0]  d_low;

    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));
    assign c2      = adder_result_i[AW];
    assign d_low   = adder_result_i[OPW-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_sub_q    <= 1'b0;
            m_q         <= '0;
            s_q         <= '0;
            c1_q        <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            add_start_q <= 1'b0;
            add_sub_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_sub_q    <= op_sub_d;
            m_q         <= m_d;
            s_q         <= s_d;
            c1_q        <= c1_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            add_start_q <= add_start_d;
            add_sub_q   <= add_sub_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_q;
        m_d         = m_q;
        s_d         = s_q;
        c1_d        = c1_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        error_d     = error_q;
        add_start_d = 1'b0;
        add_sub_d   = add_sub_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    // Adder outputs are loaded here so the start pulse lands in the ISSUE cycle.
                    op_sub_d    = op_sub_i;
                    m_d         = in_m_i;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    add_start_d = 1'b1;
                    add_sub_d   = op_sub_i;
                    add_a_d     = {2'b00, in_a_i};
                    add_b_d     = {2'b00, in_b_i};
                    state_d     = StIssue1;
                end
            end
            StIssue1: begin
                cnt_d   = '0;
                state_d = StWait1;
            end
            StWait1: begin
                if (adder_done_i) begin
                    s_d         = adder_result_i[OPW-1:0];
                    c1_d        = adder_result_i[AW];
                    add_start_d = 1'b1;
                    add_sub_d   = ~op_sub_q;
                    add_a_d     = adder_result_i[AW-1:0];
                    add_b_d     = {2'b00, m_q};
                    state_d     = StIssue2;
                end else if (timeout) begin
                    state_d   = StErr;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    add_sub_d = 1'b0;
                    add_a_d   = '0;
                    add_b_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StIssue2: begin
                cnt_d   = '0;
                state_d = StWait2;
            end
            StWait2: begin
                if (adder_done_i) begin
                    // c2: S >= m for add; c1: no borrow in a - b for sub.
                    if (op_sub_q) begin
                        result_d = c1_q ? s_q : d_low;
                    end else begin
                        result_d = c2 ? d_low : s_q;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFin;
                end else if (timeout) begin
                    state_d   = StErr;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    add_sub_d = 1'b0;
                    add_a_d   = '0;
                    add_b_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign result_o         = result_q;
    assign done_o           = done_q;
    assign busy_o           = busy_q;
    assign error_o          = error_q;
    assign adder_start_o    = add_start_q;
    assign adder_subtract_o = add_sub_q;
    assign adder_in_a_o     = add_a_q;
    assign adder_in_b_o     = add_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a behavioural 5-cycle adder and a result scoreboard.
module tb_mod_addsub_ctrl;

    localparam int unsigned OPW = 512;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op_sub;
    logic [OPW-1:0]   in_a, in_b, in_m;
    logic [OPW-1:0]   result;
    logic             done, busy, error;
    logic             adder_start, adder_subtract;
    logic [OPW+1:0]   adder_in_a, adder_in_b;
    logic [OPW+2:0]   adder_result;
    logic             adder_done;

    int checks = 0;
    int errors = 0;
    logic [OPW-1:0] sb[$];

    // Adder model
    logic [2:0]     acnt;
    logic           hang;
    logic           lsub;
    logic [OPW+1:0] la, lb;

    // Monitor state
    int         starts_n;
    logic [1:0] sub_bits;

    mod_addsub_ctrl #(.OPW(OPW), .MAX_WAIT(31)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .op_sub_i         (op_sub),
        .in_a_i           (in_a),
        .in_b_i           (in_b),
        .in_m_i           (in_m),
        .result_o         (result),
        .done_o           (done),
        .busy_o           (busy),
        .error_o          (error),
        .adder_start_o    (adder_start),
        .adder_subtract_o (adder_subtract),
        .adder_in_a_o     (adder_in_a),
        .adder_in_b_o     (adder_in_b),
        .adder_result_i   (adder_result),
        .adder_done_i     (adder_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load edge plus 5 compute edges; done stays high until the next start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acnt         <= '0;
            adder_done   <= 1'b0;
            adder_result <= '0;
            la           <= '0;
            lb           <= '0;
            lsub         <= 1'b0;
        end else if (adder_start) begin
            la         <= adder_in_a;
            lb         <= adder_in_b;
            lsub       <= adder_subtract;
            acnt       <= 3'd5;
            adder_done <= 1'b0;
        end else if (acnt != 0) begin
            acnt <= acnt - 3'd1;
            if (acnt == 3'd1 && !hang) begin
                adder_done   <= 1'b1;
                adder_result <= lsub ? ({1'b0, la} + {1'b0, ~lb} + 515'd1)
                                     : ({1'b0, la} + {1'b0, lb});
            end
        end
    end

    always @(negedge clk) begin
        if (adder_start) begin
            starts_n = starts_n + 1;
            sub_bits = {sub_bits[0], adder_subtract};
        end
    end

    function automatic logic [OPW-1:0] model(input logic op, input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b, input logic [OPW-1:0] m);
        logic [OPW+1:0] t;
        if (!op) begin
            t = {2'b00, a} + {2'b00, b};
            if (t >= {2'b00, m}) t = t - {2'b00, m};
        end else if (a >= b) begin
            t = {2'b00, a} - {2'b00, b};
        end else begin
            t = {2'b00, a} + {2'b00, m} - {2'b00, b};
        end
        return t[OPW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [OPW+1:0] obs, input logic [OPW+1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        logic [OPW-1:0] exp;
        if (sb.size() == 0) begin
            chk({tag, " sb_nonempty"}, 0, 1);
        end else begin
            exp = sb.pop_front();
            chk({tag, " result"}, {2'b00, result}, {2'b00, exp});
        end
    endtask

    task automatic run_req(input string tag, input logic op, input logic [OPW-1:0] a,
                           input logic [OPW-1:0] b, input logic [OPW-1:0] m);
        int lat = 0;
        int busy_cnt = 0;
        logic [OPW-1:0] held;
        sb.push_back(model(op, a, b, m));
        starts_n = 0;
        sub_bits = '0;
        op_sub = op;
        in_a = a;
        in_b = b;
        in_m = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " error_cleared"}, {513'd0, error}, 0);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk({tag, " latency"}, lat, 15);
        chk({tag, " busy_cycles"}, busy_cnt, 14);
        chk({tag, " adder_starts"}, starts_n, 2);
        chk({tag, " subtract_seq"}, {512'd0, sub_bits}, {512'd0, op, ~op});
        if (lat != 0) chk_result(tag);
        held = result;
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {513'd0, done}, 0);
        chk({tag, " result_held"}, {2'b00, result}, {2'b00, held});
    endtask

    initial begin
        logic [OPW-1:0] big_m, big_b;
        int nd;
        hang   = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_m   = '0;
        starts_n = 0;
        sub_bits = '0;
        repeat (3) @(negedge clk);
        chk("rst done", {513'd0, done}, 0);
        chk("rst busy", {513'd0, busy}, 0);
        chk("rst error", {513'd0, error}, 0);
        chk("rst adder_start", {513'd0, adder_start}, 0);
        chk("rst result", {2'b00, result}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_req("add7p9", 1'b0, 512'd7, 512'd9, 512'd13);
        run_req("add5p3", 1'b0, 512'd5, 512'd3, 512'd13);
        run_req("sub3m5", 1'b1, 512'd3, 512'd5, 512'd13);
        run_req("sub9m4", 1'b1, 512'd9, 512'd4, 512'd13);
        big_m = '1;
        big_b = '1;
        big_b[0] = 1'b0;
        run_req("subbig", 1'b1, 512'd0, big_b, big_m);

        // start held high: one acceptance per IDLE visit
        nd = 0;
        starts_n = 0;
        op_sub = 1'b0;
        in_a = 512'd7;
        in_b = 512'd9;
        in_m = 512'd13;
        repeat (3) sb.push_back(model(1'b0, 512'd7, 512'd9, 512'd13));
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 47; k++) begin
            if (done) begin
                nd++;
                chk_result("hold");
                if (nd == 1) chk("hold first_done", k, 15);
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("hold done_count", nd, 3);
        chk("hold adder_starts", starts_n, 6);

        // extra starts during WAIT and FIN, inputs changed after acceptance
        nd = 0;
        sb.push_back(model(1'b0, 512'd7, 512'd9, 512'd13));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                nd++;
                chk_result("extra");
            end
            if (k == 5) begin
                start = 1'b1;
                in_a = 512'd1;
                op_sub = 1'b1;
            end else if (k == 15) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("extra done_count", nd, 1);

        // adder never completes: timeout
        hang = 1'b1;
        nd = 0;
        op_sub = 1'b0;
        in_a = 512'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done) nd++;
            if (k == 32) chk("tmo error_not_yet", {513'd0, error}, 0);
            if (k == 33) begin
                chk("tmo error_set", {513'd0, error}, 1);
                chk("tmo busy_low", {513'd0, busy}, 0);
                chk("tmo adder_in_a_zero", adder_in_a, 0);
            end
            @(negedge clk);
        end
        chk("tmo no_done", nd, 0);
        chk("tmo error_sticky", {513'd0, error}, 1);
        hang = 1'b0;
        run_req("after_tmo", 1'b0, 512'd7, 512'd9, 512'd13);

        // reset during WAIT2
        op_sub = 1'b0;
        in_a = 512'd7;
        in_b = 512'd9;
        in_m = 512'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst result", {2'b00, result}, 0);
        chk("mid_rst busy", {513'd0, busy}, 0);
        chk("mid_rst adder_in_a", adder_in_a, 0);
        chk("mid_rst adder_in_b", adder_in_b, 0);
        chk("mid_rst adder_sub", {513'd0, adder_subtract}, 0);
        chk("mid_rst misc", {510'd0, done, error, adder_start}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("mid_rst no_spurious_done", nd, 0);
        run_req("after_rst", 1'b1, 512'd9, 512'd4, 512'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
